// File: rtl/vga_draw_arbiter.sv
// rtl/vga_draw_arbiter.sv - round-robin arbiter sharing one VGA pixel port among four drawing engines
//
// Purpose: grants the VGA plot port to one of four drawing engines at a time.
// A grant runs IDLE -> WARMUP (2 cycles) -> DRAW (until done or watchdog) ->
// RELEASE (1 cycle) -> IDLE. There is no preemption.
//
// Ports:
//   clk, resetn        clock and synchronous active-low reset
//   req[3:0]           level request per engine
//   eng_done[3:0]      level done flag per engine; may stay high after completion
//   eng_x/y/colour     packed per-engine pixel data (8/7/9 bits per engine)
//   eng_enable[3:0]    one-hot run enable to the granted engine (WARMUP and DRAW)
//   x, y, colour, plot VGA pixel port; pixel fields are zero whenever plot is low
//   busy               high in every state except IDLE
//   grant_id[1:0]      index of the current or most recent grant
//   timeout            one-cycle pulse on the cycle the watchdog expires
`timescale 1ns/1ps
module vga_draw_arbiter #(
   parameter int MAX_CYCLES = 4095
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [3:0]  req,
   input  logic [3:0]  eng_done,
   input  logic [31:0] eng_x,
   input  logic [27:0] eng_y,
   input  logic [35:0] eng_colour,
   output logic [3:0]  eng_enable,
   output logic [7:0]  x,
   output logic [6:0]  y,
   output logic [8:0]  colour,
   output logic        plot,
   output logic        busy,
   output logic [1:0]  grant_id,
   output logic        timeout
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WARMUP  = 2'd1,
      S_DRAW    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   // Counter value on the last DRAW cycle a grant is allowed.
   localparam logic [15:0] WD_LAST = 16'(MAX_CYCLES - 1);

   state_t      state_q, state_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [1:0]  grant_id_q, grant_id_d;
   logic [15:0] wd_cnt_q, wd_cnt_d;
   logic        warm_q, warm_d;

   logic        rr_found;
   logic [1:0]  rr_winner;
   logic [1:0]  rr_idx;
   logic        gnt_done;
   logic        wd_expired;

   // Round-robin search: walk from the highest offset down so the lowest
   // offset from ptr_q that is requesting ends up as the winner.
   always_comb begin
      rr_found  = 1'b0;
      rr_winner = ptr_q;
      rr_idx    = ptr_q;
      for (int i = 3; i >= 0; i--) begin
         rr_idx = ptr_q + 2'(i);
         if (req[rr_idx]) begin
            rr_found  = 1'b1;
            rr_winner = rr_idx;
         end
      end
   end

   assign gnt_done   = eng_done[grant_id_q];
   assign wd_expired = (wd_cnt_q == WD_LAST);

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_id_d = grant_id_q;
      wd_cnt_d   = wd_cnt_q;
      warm_d     = warm_q;
      eng_enable = 4'b0000;
      plot       = 1'b0;
      x          = 8'd0;
      y          = 7'd0;
      colour     = 9'd0;
      timeout    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rr_found) begin
               grant_id_d = rr_winner;
               warm_d     = 1'b0;
               state_d    = S_WARMUP;
            end
         end

         S_WARMUP: begin
            // eng_done is deliberately not looked at here: an engine may still
            // be showing done from its previous job.
            eng_enable = 4'b0001 << grant_id_q;
            if (warm_q) begin
               wd_cnt_d = 16'd0;
               state_d  = S_DRAW;
            end else begin
               warm_d = 1'b1;
            end
         end

         S_DRAW: begin
            eng_enable = 4'b0001 << grant_id_q;
            plot       = 1'b1;
            x          = eng_x[int'(grant_id_q) * 8 +: 8];
            y          = eng_y[int'(grant_id_q) * 7 +: 7];
            colour     = eng_colour[int'(grant_id_q) * 9 +: 9];
            wd_cnt_d   = wd_cnt_q + 16'd1;
            // Done wins over a coinciding watchdog expiry.
            if (gnt_done) begin
               ptr_d   = grant_id_q + 2'd1;
               state_d = S_RELEASE;
            end else if (wd_expired) begin
               timeout = 1'b1;
               ptr_d   = grant_id_q + 2'd1;
               state_d = S_RELEASE;
            end
         end

         S_RELEASE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy     = (state_q != S_IDLE);
   assign grant_id = grant_id_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         ptr_q      <= 2'd0;
         grant_id_q <= 2'd0;
         wd_cnt_q   <= 16'd0;
         warm_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_id_q <= grant_id_d;
         wd_cnt_q   <= wd_cnt_d;
         warm_q     <= warm_d;
      end
   end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb/tb_vga_draw_arbiter.sv - self-checking bench for vga_draw_arbiter
`timescale 1ns/1ps
module tb_vga_draw_arbiter;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [3:0]  req = 4'd0;
   logic [3:0]  eng_done = 4'd0;
   logic [31:0] eng_x = 32'd0;
   logic [27:0] eng_y = 28'd0;
   logic [35:0] eng_colour = 36'd0;

   logic [3:0] o_enable, p_enable, m_enable;
   logic [7:0] o_x, p_x, m_x;
   logic [6:0] o_y, p_y, m_y;
   logic [8:0] o_colour, p_colour, m_colour;
   logic       o_plot, p_plot, m_plot;
   logic       o_busy, p_busy, m_busy;
   logic [1:0] o_grant, p_grant, m_grant;
   logic       o_timeout, p_timeout, m_timeout;

   bit use16 = 1'b0;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   vga_draw_arbiter dut (
      .clk(clk), .resetn(resetn), .req(req), .eng_done(eng_done),
      .eng_x(eng_x), .eng_y(eng_y), .eng_colour(eng_colour),
      .eng_enable(o_enable), .x(o_x), .y(o_y), .colour(o_colour),
      .plot(o_plot), .busy(o_busy), .grant_id(o_grant), .timeout(o_timeout)
   );

   vga_draw_arbiter #(.MAX_CYCLES(16)) dut16 (
      .clk(clk), .resetn(resetn), .req(req), .eng_done(eng_done),
      .eng_x(eng_x), .eng_y(eng_y), .eng_colour(eng_colour),
      .eng_enable(p_enable), .x(p_x), .y(p_y), .colour(p_colour),
      .plot(p_plot), .busy(p_busy), .grant_id(p_grant), .timeout(p_timeout)
   );

   assign m_enable  = use16 ? p_enable  : o_enable;
   assign m_x       = use16 ? p_x       : o_x;
   assign m_y       = use16 ? p_y       : o_y;
   assign m_colour  = use16 ? p_colour  : o_colour;
   assign m_plot    = use16 ? p_plot    : o_plot;
   assign m_busy    = use16 ? p_busy    : o_busy;
   assign m_grant   = use16 ? p_grant   : o_grant;
   assign m_timeout = use16 ? p_timeout : o_timeout;

   typedef struct {
      logic [3:0] req;
      int         done_at;   // plotted cycle carrying done; 0 = never
      bit         stuck;     // done held high from the start
      bit         drop;      // req dropped during WARMUP
      bit         use16;     // observe the MAX_CYCLES=16 instance
      bit         pre_reset;
      int         exp_gid;
      int         exp_plots;
      int         exp_tmo;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      req = 4'd0;
      eng_done = 4'd0;
      resetn = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   function automatic int onehot_idx(input logic [3:0] v);
      case (v)
         4'b0001: return 0;
         4'b0010: return 1;
         4'b0100: return 2;
         4'b1000: return 3;
         default: return -1;
      endcase
   endfunction

   // Entered and left just after a rising edge with the DUT in IDLE.
   task automatic run_row(input string nm, input vec_t v);
      int gid = -1, plots = 0, enables = 0, rels = 0, tmo = 0, tmo_at = -1;
      int first_plot = -1, data_err = 0, en_err = 0, idle_busy = 0;
      bit hung = 1'b1;
      if (v.stuck) eng_done = 4'b1111;
      req = v.req;
      for (int c = 1; c <= 5000; c++) begin
         @(posedge clk);
         #1;
         eng_x = $urandom;
         eng_y = 28'($urandom);
         eng_colour = {4'($urandom), $urandom};
         if (m_plot) begin
            plots++;
            if (!v.stuck)
               eng_done = (v.done_at > 0 && plots >= v.done_at) ? (4'b0001 << v.exp_gid) : 4'b0000;
         end
         #1;
         if (gid < 0 && m_busy) gid = int'(m_grant);
         if (m_enable != 4'd0) begin
            enables++;
            if (m_enable !== (4'b0001 << v.exp_gid)) en_err++;
         end
         if (m_plot) begin
            if (first_plot < 0) first_plot = c;
            if (m_x !== eng_x[8 * v.exp_gid +: 8] || m_y !== eng_y[7 * v.exp_gid +: 7] ||
                m_colour !== eng_colour[9 * v.exp_gid +: 9]) data_err++;
         end else if (m_x !== 8'd0 || m_y !== 7'd0 || m_colour !== 9'd0) begin
            data_err++;
         end
         if (m_timeout) begin
            tmo++;
            tmo_at = m_plot ? plots : -1;
         end
         if (v.drop && m_enable != 4'd0 && !m_plot) req = 4'd0;
         if (m_busy && m_enable == 4'd0) begin
            rels++;
            req = 4'd0;
            if (!v.stuck) eng_done = 4'd0;
         end
         if (!m_busy) begin
            hung = 1'b0;
            break;
         end
      end
      eng_done = 4'd0;
      req = 4'd0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (m_busy) idle_busy++;
      end
      chk({nm, "_hang"}, int'(hung), 0);
      chk({nm, "_grant"}, gid, v.exp_gid);
      chk({nm, "_plots"}, plots, v.exp_plots);
      chk({nm, "_enables"}, enables, v.exp_plots + 2);
      chk({nm, "_release"}, rels, 1);
      chk({nm, "_latency"}, first_plot, 3);
      chk({nm, "_timeout"}, tmo, v.exp_tmo);
      if (v.exp_tmo != 0) chk({nm, "_timeout_at"}, tmo_at, v.exp_plots);
      chk({nm, "_pixel"}, data_err, 0);
      chk({nm, "_onehot"}, en_err, 0);
      chk({nm, "_no_regrant"}, idle_busy, 0);
   endtask

   vec_t vecs[11];

   initial begin
      int ng, rel, k, found;
      bit prev;
      int g[5];
      int gexp[5];

      vecs[0]  = '{4'b0001, 3200, 1'b0, 1'b0, 1'b0, 1'b1, 0, 3200, 0};
      vecs[1]  = '{4'b0100, 0,    1'b1, 1'b0, 1'b0, 1'b0, 2, 1,    0};
      vecs[2]  = '{4'b1111, 5,    1'b0, 1'b0, 1'b0, 1'b0, 3, 5,    0};
      vecs[3]  = '{4'b0110, 2,    1'b0, 1'b0, 1'b0, 1'b0, 1, 2,    0};
      vecs[4]  = '{4'b0011, 1,    1'b0, 1'b0, 1'b0, 1'b0, 0, 1,    0};
      vecs[5]  = '{4'b1001, 4,    1'b0, 1'b0, 1'b0, 1'b0, 3, 4,    0};
      vecs[6]  = '{4'b0001, 7,    1'b0, 1'b1, 1'b0, 1'b0, 0, 7,    0};
      vecs[7]  = '{4'b1000, 0,    1'b0, 1'b0, 1'b0, 1'b0, 3, 4095, 1};
      vecs[8]  = '{4'b0010, 0,    1'b0, 1'b0, 1'b1, 1'b1, 1, 16,   1};
      vecs[9]  = '{4'b0010, 16,   1'b0, 1'b0, 1'b1, 1'b0, 1, 16,   0};
      vecs[10] = '{4'b1110, 15,   1'b0, 1'b0, 1'b1, 1'b0, 2, 15,   0};

      do_reset();
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_plot", int'(o_plot), 0);
      chk("rst_enable", int'(o_enable), 0);
      chk("rst_grant", int'(o_grant), 0);
      chk("rst_timeout", int'(o_timeout), 0);
      chk("rst_pixel", int'({o_x, o_y, o_colour}), 0);

      for (int i = 0; i < 11; i++) begin
         if (vecs[i].pre_reset) do_reset();
         use16 = vecs[i].use16;
         run_row($sformatf("row%0d", i), vecs[i]);
      end
      use16 = 1'b0;

      // All four engines requesting continuously from reset.
      do_reset();
      gexp = '{0, 1, 2, 3, 0};
      ng = 0; rel = 0; k = 0; prev = 1'b0;
      req = 4'b1111;
      for (int c = 0; c < 300 && ng < 5; c++) begin
         @(posedge clk);
         #1;
         if (o_enable != 4'd0 && !prev) begin
            g[ng] = onehot_idx(o_enable);
            chk($sformatf("rr_grant_id%0d", ng), int'(o_grant), gexp[ng]);
            chk($sformatf("rr_release_before%0d", ng), rel, ng);
            ng++;
            k = 0;
         end
         if (o_plot) begin
            k++;
            if (k >= 2) eng_done = o_enable;
         end
         if (o_busy && o_enable == 4'd0) begin
            rel++;
            eng_done = 4'd0;
         end
         prev = (o_enable != 4'd0);
      end
      chk("rr_grants_seen", ng, 5);
      for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), (i < ng) ? g[i] : -1, gexp[i]);

      // Reset in the middle of a DRAW must also clear the round-robin pointer.
      do_reset();
      run_row("pre_abort", '{4'b0010, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 0});
      req = 4'b0100;
      found = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (o_plot) begin
            found = 1;
            break;
         end
      end
      chk("abort_reached_draw", found, 1);
      @(posedge clk);
      #1;
      resetn = 1'b0;
      req = 4'd0;
      @(posedge clk);
      #1;
      chk("abort_enable", int'(o_enable), 0);
      chk("abort_plot", int'(o_plot), 0);
      chk("abort_busy", int'(o_busy), 0);
      chk("abort_grant", int'(o_grant), 0);
      chk("abort_timeout", int'(o_timeout), 0);
      chk("abort_pixel", int'({o_x, o_y, o_colour}), 0);
      resetn = 1'b1;
      run_row("post_abort", '{4'b1010, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3, 0});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
